// File: rtl/bridge_pkg.sv
// Shared constants and FSM state encoding for the CPU-to-peripheral bridge.
package bridge_pkg;
   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;
endpackage

// File: rtl/bridge_addr_decoder.sv
// Combinational window decoder: byte address -> one-hot device hit plus miss flag.
module bridge_addr_decoder
   import bridge_pkg::*;
#(
   parameter int                         NUM_DEV  = 3,
   parameter logic [BUS_AW*NUM_DEV-1:0]  DEV_BASE = {32'h7f20, 32'h7f10, 32'h7f00},
   parameter int                         DEV_SPAN = 12
)(
   input  logic [BUS_AW-1:0]  i_addr,
   output logic [NUM_DEV-1:0] o_hit,
   output logic               o_miss
);

   // Scan from the top so the lowest-index window is written last and wins overlaps.
   // The offset form (addr - base) < span is evaluated modulo 2^32.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      o_hit = '0;
      for (int i = NUM_DEV - 1; i >= 0; i--) begin
         if ((i_addr - DEV_BASE[BUS_AW*i +: BUS_AW]) < BUS_AW'(DEV_SPAN)) begin
            o_hit    = '0;
            o_hit[i] = 1'b1;
         end
      end
   end

   assign o_miss = ~|o_hit;

endmodule

// File: rtl/multi_dev_bridge.sv
// Request/ready bridge from the CPU MEM stage to NUM_DEV memory-mapped devices,
// with multi-cycle acks, bus-error reporting and registered interrupt aggregation.
module multi_dev_bridge
   import bridge_pkg::*;
#(
   parameter int                         NUM_DEV  = 3,
   parameter logic [BUS_AW*NUM_DEV-1:0]  DEV_BASE = {32'h7f20, 32'h7f10, 32'h7f00},
   parameter int                         DEV_SPAN = 12,
   parameter int                         TIMEOUT  = 15,
   parameter int                         HWINT_W  = 6
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       pr_req,
   input  logic                       pr_we,
   input  logic [BUS_AW-1:0]          pr_addr,
   input  logic [BUS_DW-1:0]          pr_wd,
   input  logic [3:0]                 pr_be,
   output logic [BUS_DW-1:0]          pr_rd,
   output logic                       pr_ready,
   output logic                       pr_err,
   output logic [NUM_DEV-1:0]         dev_sel,
   output logic                       dev_we,
   output logic [BUS_AW-1:0]          dev_addr,
   output logic [BUS_DW-1:0]          dev_wd,
   output logic [3:0]                 dev_be,
   input  logic [BUS_DW*NUM_DEV-1:0]  dev_rd,
   input  logic [NUM_DEV-1:0]         dev_ack,
   input  logic [NUM_DEV-1:0]         dev_irq,
   output logic [HWINT_W-1:0]         hw_int
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_t               r_state;
   state_t               w_next;
   logic [NUM_DEV-1:0]   w_hit;
   logic                 w_miss;
   logic                 w_reject;
   logic                 w_ack;
   logic                 w_timeout;
   logic [BUS_DW-1:0]    w_sel_rd;
   logic [HWINT_W-1:0]   w_hw_int;

   logic [NUM_DEV-1:0]   r_sel;
   logic                 r_we;
   logic [BUS_AW-1:0]    r_addr;
   logic [BUS_DW-1:0]    r_wd;
   logic [3:0]           r_be;
   logic [BUS_DW-1:0]    r_rd;
   logic                 r_err;
   logic [CNT_W-1:0]     r_cnt;
   logic [NUM_DEV-1:0]   r_irq;

   bridge_addr_decoder #(
      .NUM_DEV  (NUM_DEV),
      .DEV_BASE (DEV_BASE),
      .DEV_SPAN (DEV_SPAN)
   ) u_decoder (
      .i_addr (pr_addr),
      .o_hit  (w_hit),
      .o_miss (w_miss)
   );

   // A write with no byte lanes enabled is rejected exactly like an unmapped address.
   assign w_reject  = w_miss | (pr_we & (pr_be == 4'b0000));
   assign w_ack     = |(dev_ack & r_sel);
   assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      w_sel_rd = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         if (r_sel[i]) w_sel_rd = w_sel_rd | dev_rd[BUS_DW*i +: BUS_DW];
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (pr_req) w_next = w_reject ? ST_DONE : ST_ACCESS;
         ST_ACCESS: if (w_ack || w_timeout) w_next = ST_DONE;
         ST_DONE:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wd    <= '0;
         r_be    <= '0;
         r_rd    <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
         r_irq   <= '0;
      end else begin
         r_state <= w_next;
         r_irq   <= dev_irq;
         unique case (r_state)
            ST_IDLE: begin
               if (pr_req) begin
                  r_we   <= pr_we;
                  r_addr <= pr_addr;
                  r_wd   <= pr_wd;
                  r_be   <= pr_be;
                  r_cnt  <= '0;
                  if (w_reject) begin
                     r_sel <= '0;
                     r_rd  <= '0;
                     r_err <= 1'b1;
                  end else begin
                     r_sel <= w_hit;
                  end
               end
            end
            ST_ACCESS: begin
               r_cnt <= r_cnt + 1'b1;
               // An ack on the final counted cycle takes priority over the timeout.
               if (w_ack) begin
                  r_sel <= '0;
                  r_rd  <= r_we ? '0 : w_sel_rd;
                  r_err <= 1'b0;
               end else if (w_timeout) begin
                  r_sel <= '0;
                  r_rd  <= '0;
                  r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_hw_int                = '0;
      w_hw_int[NUM_DEV-1:0]   = r_irq;
   end

   assign pr_rd    = r_rd;
   assign pr_err   = r_err;
   assign pr_ready = (r_state == ST_DONE);
   assign dev_sel  = r_sel;
   assign dev_we   = r_we & (r_state == ST_ACCESS);
   assign dev_addr = r_addr;
   assign dev_wd   = r_wd;
   assign dev_be   = r_be;
   assign hw_int   = w_hw_int;

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Self-checking bench for multi_dev_bridge: directed vector table, hand sequences, randomized model check.
module tb_multi_dev_bridge;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  be;
      int          ack_lat;   // access cycle in which the device acks; 0 or >15 = never
      logic [31:0] rdata;
      logic [2:0]  irq;
      logic [2:0]  exp_sel;
      int          exp_lat;   // cycles from request to pr_ready
      logic        exp_err;
      logic [31:0] exp_rd;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        pr_req, pr_we;
   logic [31:0] pr_addr, pr_wd;
   logic [3:0]  pr_be;
   logic [31:0] pr_rd;
   logic        pr_ready, pr_err;
   logic [2:0]  dev_sel;
   logic        dev_we;
   logic [31:0] dev_addr, dev_wd;
   logic [3:0]  dev_be;
   logic [95:0] dev_rd;
   logic [2:0]  dev_ack, dev_irq;
   logic [5:0]  hw_int;

   // second instance with overlapping windows 0x7f00..0x7f0b and 0x7f08..0x7f13
   logic [31:0] d2_rd, d2_addr, d2_wd;
   logic        d2_ready, d2_err, d2_we;
   logic [1:0]  d2_sel, d2_hw_int;
   logic [3:0]  d2_be;

   int n_vec = 0;
   int n_err = 0;
   vec_t vecs[11];

   always #5 clk = ~clk;

   multi_dev_bridge dut (
      .clk(clk), .reset(reset), .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr),
      .pr_wd(pr_wd), .pr_be(pr_be), .pr_rd(pr_rd), .pr_ready(pr_ready), .pr_err(pr_err),
      .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
      .dev_be(dev_be), .dev_rd(dev_rd), .dev_ack(dev_ack), .dev_irq(dev_irq), .hw_int(hw_int)
   );

   multi_dev_bridge #(
      .NUM_DEV(2), .DEV_BASE({32'h7f08, 32'h7f00}), .DEV_SPAN(12), .TIMEOUT(15), .HWINT_W(2)
   ) dut2 (
      .clk(clk), .reset(reset), .pr_req(pr_req), .pr_we(pr_we), .pr_addr(pr_addr),
      .pr_wd(pr_wd), .pr_be(pr_be), .pr_rd(d2_rd), .pr_ready(d2_ready), .pr_err(d2_err),
      .dev_sel(d2_sel), .dev_we(d2_we), .dev_addr(d2_addr), .dev_wd(d2_wd),
      .dev_be(d2_be), .dev_rd(dev_rd[63:0]), .dev_ack(dev_ack[1:0]), .dev_irq(dev_irq[1:0]),
      .hw_int(d2_hw_int)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected outcome from the address map and device behaviour, in plain arithmetic.
   function automatic vec_t predict(input vec_t v);
      vec_t        r;
      logic [31:0] bases[3];
      int          idx;
      r        = v;
      bases[0] = 32'h7f00;
      bases[1] = 32'h7f10;
      bases[2] = 32'h7f20;
      idx      = -1;
      for (int i = 2; i >= 0; i--)
         if (v.addr >= bases[i] && v.addr < bases[i] + 32'd12) idx = i;
      if (idx < 0 || (v.we && v.be == 4'b0000)) begin
         r.exp_sel = 3'b000; r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rd = 32'h0;
      end else begin
         r.exp_sel = 3'b001 << idx;
         if (v.ack_lat >= 1 && v.ack_lat <= 15) begin
            r.exp_lat = v.ack_lat + 1; r.exp_err = 1'b0; r.exp_rd = v.we ? 32'h0 : v.rdata;
         end else begin
            r.exp_lat = 16; r.exp_err = 1'b1; r.exp_rd = 32'h0;
         end
      end
      return r;
   endfunction

   task automatic run_txn(input vec_t v, input string tag);
      int lat   = 0;
      int n_sel = 0;
      int n_bad = 0;
      pr_req  = 1'b1;
      pr_we   = v.we;
      pr_addr = v.addr;
      pr_wd   = v.wd;
      pr_be   = v.be;
      dev_ack = 3'b000;
      tick();
      pr_req  = 1'b0;
      for (int cyc = 1; cyc <= 40 && lat == 0; cyc++) begin
         if (v.irq != 3'b000 && v.exp_lat >= 5) begin
            if (cyc == 3) check({tag, " hw_int pulse"}, {26'h0, hw_int}, {29'h0, v.irq});
            if (cyc == 4) check({tag, " hw_int clear"}, {26'h0, hw_int}, 32'h0);
         end
         if (pr_ready) begin
            lat = cyc;
         end else begin
            if (dev_sel != 3'b000) begin
               n_sel++;
               if (dev_sel != v.exp_sel || dev_we != v.we || dev_addr != v.addr ||
                   dev_wd != v.wd || dev_be != v.be) n_bad++;
            end else if (dev_we) begin
               n_bad++;
            end
            dev_ack = (3'($urandom) & ~v.exp_sel) | ((cyc == v.ack_lat) ? v.exp_sel : 3'b000);
            dev_rd  = {$urandom, $urandom, $urandom};
            if (cyc == v.ack_lat)
               for (int i = 0; i < 3; i++) if (v.exp_sel[i]) dev_rd[32*i +: 32] = v.rdata;
            dev_irq = (cyc == 2) ? v.irq : 3'b000;
            tick();
         end
      end
      check({tag, " latency"}, lat, v.exp_lat);
      check({tag, " pr_err"}, {31'h0, pr_err}, {31'h0, v.exp_err});
      check({tag, " pr_rd"}, pr_rd, v.exp_rd);
      check({tag, " sel cycles"}, n_sel, v.exp_lat - 1);
      check({tag, " dev bus"}, n_bad, 0);
      dev_ack = 3'b000;
      dev_irq = 3'b000;
      tick();
      check({tag, " ready pulse"}, {31'h0, pr_ready}, 32'h0);
      check({tag, " rd hold"}, pr_rd, v.exp_rd);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n_rdy;

      //           we    addr          wd            be       lat rdata         irq     sel     lat err  rd
      vecs[0]  = '{1'b0, 32'h7f14, 32'h0,        4'hf,    1, 32'hDEADBEEF, 3'b000, 3'b010,  2, 1'b0, 32'hDEADBEEF};
      vecs[1]  = '{1'b0, 32'h7f0c, 32'h0,        4'hf,    1, 32'h0,        3'b000, 3'b000,  1, 1'b1, 32'h0};
      vecs[2]  = '{1'b1, 32'h7f04, 32'h12345678, 4'b0011, 3, 32'h0,        3'b000, 3'b001,  4, 1'b0, 32'h0};
      vecs[3]  = '{1'b0, 32'h7f20, 32'h0,        4'hf,    0, 32'h0,        3'b101, 3'b100, 16, 1'b1, 32'h0};
      vecs[4]  = '{1'b0, 32'h7f20, 32'h0,        4'hf,   15, 32'hA5A50001, 3'b000, 3'b100, 16, 1'b0, 32'hA5A50001};
      vecs[5]  = '{1'b1, 32'h7f10, 32'h55AA55AA, 4'h0,    1, 32'h0,        3'b000, 3'b000,  1, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, 32'h7f1b, 32'h0,        4'hf,    2, 32'h0BADF00D, 3'b000, 3'b010,  3, 1'b0, 32'h0BADF00D};
      vecs[7]  = '{1'b0, 32'h7eff, 32'h0,        4'hf,    1, 32'h0,        3'b000, 3'b000,  1, 1'b1, 32'h0};
      vecs[8]  = '{1'b0, 32'h7f2c, 32'h0,        4'hf,    1, 32'h0,        3'b000, 3'b000,  1, 1'b1, 32'h0};
      vecs[9]  = '{1'b0, 32'h7f2b, 32'h0,        4'hf,    4, 32'h13579BDF, 3'b011, 3'b100,  5, 1'b0, 32'h13579BDF};
      vecs[10] = '{1'b0, 32'h7f00, 32'h0,        4'hf,    1, 32'hCAFE0000, 3'b000, 3'b001,  2, 1'b0, 32'hCAFE0000};

      reset = 1'b1; pr_req = 1'b0; pr_we = 1'b0; pr_addr = '0; pr_wd = '0; pr_be = '0;
      dev_rd = '0; dev_ack = '0; dev_irq = 3'b111;
      tick();
      tick();
      check("reset pr_rd", pr_rd, 32'h0);
      check("reset pr_ready", {31'h0, pr_ready}, 32'h0);
      check("reset pr_err", {31'h0, pr_err}, 32'h0);
      check("reset dev_sel", {29'h0, dev_sel}, 32'h0);
      check("reset hw_int", {26'h0, hw_int}, 32'h0);
      reset = 1'b0; dev_irq = 3'b000;
      tick();

      // overlapping windows: 0x7f0a lies in both of dut2's windows, device 0 must win
      pr_req = 1'b1; pr_addr = 32'h7f0a; pr_be = 4'hf;
      tick();
      pr_req = 1'b0;
      check("overlap dut2 sel", {30'h0, d2_sel}, 32'h1);
      check("overlap dut sel", {29'h0, dev_sel}, 32'h1);
      dev_ack = 3'b001; dev_rd = {32'h0, 32'h0, 32'h11112222};
      tick();
      dev_ack = 3'b000;
      check("overlap dut2 ready", {31'h0, d2_ready}, 32'h1);
      check("overlap dut2 rd", d2_rd, 32'h11112222);
      tick();

      for (int i = 0; i < 11; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

      // reset in the second ACCESS cycle aborts silently
      pr_req = 1'b1; pr_we = 1'b1; pr_addr = 32'h7f20; pr_wd = 32'hFEEDFACE; pr_be = 4'hf;
      tick();
      pr_req = 1'b0;
      tick();
      check("abort sel before reset", {29'h0, dev_sel}, 32'h4);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort pr_rd", pr_rd, 32'h0);
      check("abort pr_ready", {31'h0, pr_ready}, 32'h0);
      check("abort pr_err", {31'h0, pr_err}, 32'h0);
      check("abort dev_sel", {29'h0, dev_sel}, 32'h0);
      check("abort dev_we", {31'h0, dev_we}, 32'h0);
      check("abort dev_addr", dev_addr, 32'h0);
      check("abort dev_wd", dev_wd, 32'h0);
      check("abort dev_be", {28'h0, dev_be}, 32'h0);
      n_rdy = 0;
      for (int i = 0; i < 20; i++) begin
         if (pr_ready) n_rdy++;
         tick();
      end
      check("abort no ready", n_rdy, 0);
      run_txn(vecs[0], "after abort");

      for (int i = 0; i < 40; i++) begin
         v.we      = 1'($urandom_range(0, 1));
         v.addr    = ($urandom_range(0, 7) == 0) ? $urandom : 32'h7ef8 + 32'($urandom_range(0, 56));
         v.wd      = $urandom;
         v.be      = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
         v.ack_lat = $urandom_range(0, 17);
         v.rdata   = $urandom;
         v.irq     = 3'($urandom);
         run_txn(predict(v), $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
